// File: rtl/spi_master_ctrl.sv
// SPI master for the CPU's MTC0/MFC0 path: one full-duplex, mode-0, MSB-first word per command.
// The core is stalled from the command cycle through HOLD; DONE releases it for one cycle.
module spi_master_ctrl #(
    parameter int W_DATA     = 32,
    parameter int CLK_DIV    = 2,
    parameter int W_SPI_CTRL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_SPI_CTRL-1:0] spi_ctrl,
    input  logic [W_DATA-1:0]     tx_data,
    output logic [W_DATA-1:0]     rx_data,
    output logic                  stall,
    output logic                  done,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    // Command codes; every other code behaves as SPI_NOP.
    localparam logic [W_SPI_CTRL-1:0] SPI_MOSI = W_SPI_CTRL'(1);
    localparam logic [W_SPI_CTRL-1:0] SPI_MISO = W_SPI_CTRL'(2);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(W_DATA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [W_DATA-1:0]   shift_out_q, shift_out_d;
    logic [W_DATA-1:0]   shift_in_q, shift_in_d;
    logic [W_DATA-1:0]   rx_q, rx_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;

    logic                cmd_valid;
    logic                div_end;
    logic [W_DATA-1:0]   load_word;

    assign cmd_valid = (spi_ctrl == SPI_MOSI) || (spi_ctrl == SPI_MISO);
    assign div_end   = (div_q == DIV_W'(CLK_DIV - 1));
    // MFC0 clocks out all-ones; the transfer itself is otherwise identical.
    assign load_word = (spi_ctrl == SPI_MOSI) ? tx_data : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    shift_out_d = load_word;
                    mosi_d      = load_word[W_DATA-1];
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    div_d       = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 1'b1;
                end else if (!phase_q) begin
                    // Rising edge: sample the slave's bit.
                    div_d      = '0;
                    phase_d    = 1'b1;
                    sclk_d     = 1'b1;
                    shift_in_d = {shift_in_q[W_DATA-2:0], miso};
                end else begin
                    // Falling edge: advance to the next outgoing bit, or finish.
                    div_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    if (bit_q == BIT_W'(W_DATA - 1)) begin
                        bit_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        bit_d       = bit_q + 1'b1;
                        shift_out_d = {shift_out_q[W_DATA-2:0], 1'b0};
                        mosi_d      = shift_out_q[W_DATA-2];
                    end
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    rx_d    = shift_in_q;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall   = ((state_q == S_IDLE) && cmd_valid) || (state_q == S_SETUP)
                   || (state_q == S_SHIFT) || (state_q == S_HOLD);
    assign done    = (state_q == S_DONE);
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) with an SPI slave model,
// bus monitor, and expectations derived from word-level transfer rules.
module tb_spi_master_ctrl;

    localparam int W = 32;
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] MTC0 = 2'd1;
    localparam logic [1:0] MFC0 = 2'd2;
    localparam logic [1:0] ILL  = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   ctrl  [2];
    logic [W-1:0] tx    [2];
    logic [W-1:0] rx    [2];
    logic         stall [2];
    logic         done  [2];
    logic         sclk  [2];
    logic         cs_n  [2];
    logic         mosi  [2];
    logic         miso  [2];

    spi_master_ctrl #(.W_DATA(W), .CLK_DIV(2)) dut_div2 (
        .clk(clk), .rst(rst), .spi_ctrl(ctrl[0]), .tx_data(tx[0]), .rx_data(rx[0]),
        .stall(stall[0]), .done(done[0]), .sclk(sclk[0]), .cs_n(cs_n[0]),
        .mosi(mosi[0]), .miso(miso[0])
    );

    spi_master_ctrl #(.W_DATA(W), .CLK_DIV(1)) dut_div1 (
        .clk(clk), .rst(rst), .spi_ctrl(ctrl[1]), .tx_data(tx[1]), .rx_data(rx[1]),
        .stall(stall[1]), .done(done[1]), .sclk(sclk[1]), .cs_n(cs_n[1]),
        .mosi(mosi[1]), .miso(miso[1])
    );

    int total = 0;
    int bad   = 0;

    // Bus monitor and slave: counts edges, records mosi at each rising sclk,
    // and presents slave_word MSB first, changing miso after each falling sclk.
    int           rise_cnt   [2] = '{0, 0};
    int           fall_cnt   [2] = '{0, 0};
    int           cs_low_cnt [2] = '{0, 0};
    int           sidx       [2] = '{0, 0};
    logic         sclk_prev  [2] = '{1'b0, 1'b0};
    logic         cs_prev    [2] = '{1'b1, 1'b1};
    logic [W-1:0] mosi_cap   [2] = '{'0, '0};
    logic [W-1:0] slave_word [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] === 1'b1 && sclk_prev[i] === 1'b0) begin
                rise_cnt[i]++;
                mosi_cap[i] = {mosi_cap[i][W-2:0], mosi[i]};
            end
            if (sclk[i] === 1'b0 && sclk_prev[i] === 1'b1) fall_cnt[i]++;
            if (cs_n[i] === 1'b0) cs_low_cnt[i]++;
            if (cs_n[i] === 1'b0 && cs_prev[i] === 1'b1) begin
                sidx[i] = W - 1;
                miso[i] = slave_word[i][W-1];
            end else if (cs_n[i] === 1'b0 && sclk[i] === 1'b0 && sclk_prev[i] === 1'b1) begin
                sidx[i] = sidx[i] - 1;
                miso[i] = (sidx[i] >= 0) ? slave_word[i][sidx[i]] : 1'b0;
            end else if (cs_n[i] !== 1'b0) begin
                miso[i] = 1'b0;
            end
            sclk_prev[i] = sclk[i];
            cs_prev[i]   = cs_n[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer on instance i, started in the current negedge (or the next one when
    // called from the DONE cycle of a previous transfer). Returns at the DONE negedge.
    task automatic xfer(input int i, input logic [1:0] cmd, input logic [W-1:0] txv,
                        input logic [W-1:0] sw, input int div, input bit from_done,
                        input bit scramble, input string tag);
        int lat, n, stall_n, r0, f0, c0;
        bit got;
        logic [W-1:0] exp_mosi;
        lat      = div + 2 * div * W + div + 1;
        exp_mosi = (cmd == MTC0) ? txv : '1;
        slave_word[i] = sw;
        r0 = rise_cnt[i];
        f0 = fall_cnt[i];
        c0 = cs_low_cnt[i];
        ctrl[i] = cmd;
        tx[i]   = txv;
        if (from_done) @(negedge clk);
        #1;
        check({tag, "_stall_first"}, 64'(stall[i]), 64'd1);
        n = 1;
        stall_n = 1;
        got = 1'b0;
        while (n < lat + 20) begin
            @(negedge clk);
            n++;
            if (done[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (stall[i] === 1'b1) stall_n++;
            if (cs_n[i] === 1'b1) check({tag, "_sclk_idle"}, 64'(sclk[i]), 64'd0);
            if (scramble) begin
                ctrl[i] = 2'($urandom_range(0, 3));
                tx[i]   = $urandom;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(n - 1), 64'(lat));
            check({tag, "_stall_cycles"}, 64'(stall_n), 64'(lat));
            check({tag, "_stall_at_done"}, 64'(stall[i]), 64'd0);
            check({tag, "_rx"}, 64'(rx[i]), 64'(sw));
            check({tag, "_mosi_word"}, 64'(mosi_cap[i]), 64'(exp_mosi));
            check({tag, "_rises"}, 64'(rise_cnt[i] - r0), 64'(W));
            check({tag, "_falls"}, 64'(fall_cnt[i] - f0), 64'(W));
            check({tag, "_cs_low"}, 64'(cs_low_cnt[i] - c0), 64'(lat - 1));
        end
        ctrl[i] = NOP;
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   c;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ctrl[i] = NOP;
            tx[i] = '0;
            slave_word[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_bus%0d", i),
                  64'({cs_n[i], sclk[i], mosi[i], done[i], stall[i]}), 64'(5'b10000));
            check($sformatf("reset_rx%0d", i), 64'(rx[i]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        xfer(0, MTC0, 32'hA5A50F0F, $urandom, 2, 1'b0, 1'b0, "mtc0_a5");
        @(negedge clk);
        xfer(0, MFC0, $urandom, 32'hDEADBEEF, 2, 1'b0, 1'b0, "mfc0_dead");
        repeat (5) @(negedge clk);
        check("mfc0_rx_held", 64'(rx[0]), 64'hDEADBEEF);

        for (int k = 0; k < 50; k++) begin
            ctrl[0] = ($urandom_range(0, 1) == 1) ? ILL : NOP;
            tx[0] = $urandom;
            #1;
            check("idle_nop", 64'({stall[0], cs_n[0], sclk[0], done[0]}), 64'(4'b0100));
            @(negedge clk);
        end
        ctrl[0] = NOP;

        // Reset during SHIFT bit 10 (CLK_DIV=2).
        ctrl[0] = MTC0;
        tx[0] = $urandom;
        repeat (44) @(negedge clk);
        ctrl[0] = NOP;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_bus", 64'({cs_n[0], sclk[0], stall[0], done[0]}), 64'(4'b1000));
        check("midrst_rx", 64'(rx[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        xfer(0, MTC0, $urandom, $urandom, 2, 1'b0, 1'b0, "post_rst");

        @(negedge clk);
        xfer(0, MTC0, $urandom, $urandom, 2, 1'b0, 1'b0, "b2b_first");
        xfer(0, MFC0, $urandom, 32'h13579BDF ^ $urandom, 2, 1'b1, 1'b0, "b2b_second");

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c = ($urandom_range(0, 1) == 1) ? MFC0 : MTC0;
            a = $urandom;
            b = $urandom;
            xfer(0, c, a, b, 2, 1'b0, 1'b0, $sformatf("rand_d2_%0d", k));
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c = ($urandom_range(0, 1) == 1) ? MFC0 : MTC0;
            a = $urandom;
            b = $urandom;
            xfer(1, c, a, b, 1, 1'b0, 1'b1, $sformatf("scr_d1_%0d", k));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Sequences the CPU's SPI port for the MTC0/MFC0 instructions flagged by decode on `spi_ctrl`.
- Runs a full-duplex, mode-0 (CPOL=0, CPHA=0), MSB-first SPI master transfer of one data word.
- Holds the single-cycle core stalled for the duration and presents the received word to the register-file write mux (`REG_SRC_SPI`).

Parameters:
- W_DATA, 32: transfer word width in bits; equals `W_CPU`.
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_ctrl  in  `W_SPI_CTRL`  command from decode: `SPI_NOP`, `MOSI` (MTC0), `MISO` (MFC0). Any other code = `SPI_NOP`.
- tx_data  in  W_DATA  word to send (register rt read data); sampled only at start.
- rx_data  out  W_DATA  last received word; stable between `done` pulses.
- stall  out  1  holds PC/regfile write while a transfer is pending or active.
- done  out  1  one-cycle pulse; transfer complete, rx_data valid this cycle.
- sclk  out  1  SPI clock.
- cs_n  out  1  SPI chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, sclk=0, cs_n=1, mosi=0, done=0, rx_data=0, bit and divider counters=0. This applies mid-transfer too: the bus is released the next edge and the partial word is discarded.
- stall is combinational: 1 when (IDLE and spi_ctrl is MOSI/MISO) or state is SETUP/SHIFT/HOLD; 0 in IDLE with NOP and in DONE.
- IDLE: on MOSI/MISO, latch shift_out = tx_data (MOSI) or all-ones (MISO), latch cmd, go to SETUP.
- SETUP: cs_n=0, mosi=shift_out[MSB], sclk=0. Lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT: W_DATA bit periods of 2*CLK_DIV cycles each.
  - First half: sclk=0. At its end sclk rises and miso is shifted into shift_in LSB.
  - Second half: sclk=1. At its end sclk falls, shift_out shifts left and mosi takes the next bit.
  - After the last period sclk is left at 0; go to HOLD.
- HOLD: cs_n stays 0 for CLK_DIV cycles, then cs_n=1, rx_data=shift_in; go to DONE.
- DONE: done=1 and stall=0 for exactly one cycle, so the core commits the instruction. Next state is IDLE unconditionally.
- Latency: the first cycle with stall=1 until done takes CLK_DIV + 2*CLK_DIV*W_DATA + CLK_DIV + 1 cycles. For defaults that is 133.
- The transfer is identical for both commands. For MFC0, rx_data is written to rd; for MTC0, rx_data is updated but the core ignores it.
- spi_ctrl and tx_data changes after IDLE are ignored until the next IDLE.
- Back-to-back: a command present in the IDLE cycle following DONE starts immediately. Exactly one non-stalled DONE cycle separates transfers.
- Exactly W_DATA rising and W_DATA falling sclk edges per transfer; sclk=0 whenever cs_n=1.
- Counters sized by $clog2; the bit counter wraps only via the state transition, never free-running.

Test Plan:
- MTC0, tx_data=0xA5A50F0F, CLK_DIV=2 -> cs_n low 132 cycles, 32 sclk rising edges, mosi bits sampled at rising edges = A5A50F0F MSB first, stall high 133 cycles, then done=1/stall=0 one cycle.
- MFC0, slave model drives 0xDEADBEEF on miso (changes on falling edge) -> mosi all ones, rx_data=0xDEADBEEF at done and held afterwards.
- rst=1 at SHIFT bit 10 -> next edge cs_n=1, sclk=0, stall=0 (with NOP), rx_data=0; a new MTC0 afterwards completes normally.
- spi_ctrl=NOP and spi_ctrl=illegal code for 50 cycles -> cs_n=1, sclk=0, stall=0, done never asserted.
- MTC0 immediately followed by MFC0 -> two transfers; one DONE cycle between them; second rx_data captured correctly.
- CLK_DIV=1: spi_ctrl and tx_data toggled mid-transfer -> transmitted word equals the originally latched tx_data, latency 67 cycles.
